rm_lane_release_ctrl: RTL and testbench
=======================================

# rm_lane_release_ctrl

Per-lane lifecycle controller for the runtime-monitor lane pool. It tracks how many monitored instructions occupy each lane, counts check-completion events from the monitor datapath, and issues one-cycle lane-reset pulses that feed the lane allocator's `lane_reset_i`. A per-lane watchdog force-releases lanes whose checks never complete. A flush releases every occupied lane.

## Interface

Parameters:
- `NUM_LANES`, 4: number of monitor lanes; must be a power of two and at least 2.
- `TIMEOUT_W`, 8: width of the per-lane watchdog counter.
- `TIMEOUT`, 200: idle cycles in ACTIVE before a forced release; range 1 to 2^TIMEOUT_W-1.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `alloc_valid_i` in 1: the allocator placed a monitored instruction this cycle.
- `alloc_lane0_i` in $clog2(NUM_LANES): primary lane of the allocation.
- `alloc_two_lane_i` in 1: the instruction also occupies `alloc_lane1_i`.
- `alloc_lane1_i` in $clog2(NUM_LANES): secondary lane; valid only when `alloc_two_lane_i`=1.
- `done_valid_i` in NUM_LANES: per-lane check-complete strobe; bit i retires one occupant of lane i.
- `flush_i` in 1: pipeline flush.
- `lane_reset_o` out NUM_LANES: one-cycle release pulse per lane, driven to the allocator.
- `lane_busy_o` out NUM_LANES: lane state is not IDLE.
- `timeout_o` out 1: one-cycle pulse when any watchdog fires.
- `timeout_lane_o` out $clog2(NUM_LANES): lowest-index lane whose watchdog fired; valid with `timeout_o`.
- `err_o` out 1: sticky protocol error; cleared only by reset.

## Operation

Each lane has three states, IDLE, ACTIVE and RELEASE. It also has a 2-bit occupancy count `occ` (range 0..2) and a watchdog counter `wd`.

Occupancy update for lane i, each cycle:
- `inc` = number of allocation hits on lane i. A hit is `alloc_valid_i` with `alloc_lane0_i`=i, or `alloc_valid_i` with `alloc_two_lane_i` and `alloc_lane1_i`=i. A two-lane allocation with lane0 = lane1 counts once and sets `err_o`.
- `dec` = `done_valid_i[i]`.
- New `occ` = `occ` + `inc` − `dec`, saturated to the range 0..2.
- Saturation sets `err_o`. This covers `dec` when `occ`=0 and `inc`=0, and any result above 2.

State transitions for lane i:
- IDLE → ACTIVE when `inc`=1.
- IDLE stays IDLE otherwise; a stray `dec` sets `err_o`.
- ACTIVE → RELEASE when the new `occ` is 0.
- ACTIVE → RELEASE when `wd` reaches TIMEOUT−1 with no `dec` this cycle. This is a forced release: `occ` is cleared and `timeout_o` pulses.
- ACTIVE → RELEASE when `flush_i`=1. This applies to all ACTIVE lanes, whether or not the lane has an allocation this cycle. When `flush_i`=1, allocations and done events are ignored in every state.
- RELEASE → IDLE unconditionally, unless `inc`=1 in the same cycle; then RELEASE → ACTIVE with `occ`=1 and `wd`=0. Re-allocation of a lane in its reset cycle takes priority over the release.

Watchdog:
- `wd` clears on entry to ACTIVE and on every `dec` or `inc` to the lane.
- Otherwise `wd` increments while ACTIVE; it never wraps.

Outputs:
- `lane_reset_o[i]` = (state==RELEASE). This is a decode of registered state, so it is glitch-free.
- `lane_busy_o[i]` = (state != IDLE).

## Timing

- Reset values: all lanes IDLE, `occ`=0, `wd`=0. All outputs are 0, including `err_o`, `timeout_lane_o` and `timeout_o`.
- A final `dec` sampled at edge N puts the lane in RELEASE after edge N. `lane_reset_o` is high for the cycle N→N+1; the lane is IDLE after edge N+1.
- Release latency from the last done strobe is one cycle.
- `lane_reset_o` is exactly one cycle wide per release. Back-to-back releases of the same lane require a new allocation in between.
- `timeout_o` and `timeout_lane_o` are registered. They are valid in the same cycle the forced `lane_reset_o` is high.
- If several watchdogs fire in the same cycle, all those lanes release. `timeout_lane_o` reports the lowest index.
- `flush_i` sampled at edge N: every ACTIVE lane pulses `lane_reset_o` in cycle N→N+1.
- Asynchronous reset mid-operation returns all state to reset values immediately. No pending pulse is emitted.

## Test plan

1. **Single-lane release.** Alloc lane 2, single lane; wait 5 cycles; `done_valid_i`=4'b0100 → `lane_reset_o`=4'b0100 for exactly one cycle, one cycle after the done; `lane_busy_o[2]` returns to 0; `err_o`=0.
2. **Two-lane allocation.**
   - Alloc lane0=1, lane1=3, two_lane=1, then a second alloc on lane 1.
   - Done on lane 3 → lane 3 releases only.
   - Two dones on lane 1 in consecutive cycles → lane 1 releases after the second done.
3. **Simultaneous events.**
   - Same-cycle alloc and done on lane 0 with `occ`=1 → `occ` stays 1, no reset.
   - Alloc to lane 0 during its RELEASE cycle → `lane_reset_o[0]` pulses and lane 0 is ACTIVE next cycle with `occ`=1.
4. **Watchdog.** With TIMEOUT=8, alloc lane 1 and send no dones → after 8 ACTIVE cycles, `timeout_o`=1, `timeout_lane_o`=1 and `lane_reset_o`=4'b0010 in the same cycle.
5. **Flush.** Lanes 0, 2 and 3 ACTIVE; `flush_i`=1 together with an alloc on lane 1 → `lane_reset_o`=4'b1101; lane 1 stays IDLE.
6. **Protocol errors and reset.**
   - Done on an IDLE lane → `err_o`=1 and stays 1.
   - Three allocs on one lane → `err_o`=1 and `occ` saturates at 2.
   - Assert `rst_ni`=0 mid-ACTIVE → all outputs are 0 immediately.

Source files
------------

// File: rtl/rm_lane_release_ctrl.sv
// rm_lane_release_ctrl
// ---------------------------------------------------------------------------
// Per-lane lifecycle controller for the runtime-monitor lane pool. Each lane
// counts its monitored occupants (0..2) and walks IDLE -> ACTIVE -> RELEASE.
// RELEASE lasts exactly one cycle and is decoded straight from the state
// register onto lane_reset_o. A per-lane watchdog force-releases a lane that
// sits in ACTIVE without retire activity, and a flush releases every ACTIVE
// lane at once.
//
// Strobe semantics: alloc_valid_i and done_valid_i are single-cycle event
// strobes with no back-pressure. An event counts in the cycle it is sampled
// high at the rising edge of clk_i and is never held or replayed. While
// flush_i is high, all allocation and done strobes are discarded.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   alloc_valid_i        allocator placed a monitored instruction
//   alloc_lane0_i        primary lane of that allocation
//   alloc_two_lane_i     allocation also occupies alloc_lane1_i
//   alloc_lane1_i        secondary lane (meaningful with alloc_two_lane_i)
//   done_valid_i         per-lane check-complete strobe, retires one occupant
//   flush_i              pipeline flush
//   lane_reset_o         one-cycle release pulse per lane
//   lane_busy_o          lane is not IDLE
//   timeout_o            one-cycle pulse when any watchdog fired
//   timeout_lane_o       lowest lane whose watchdog fired (with timeout_o)
//   err_o                sticky protocol error, cleared only by reset
// ---------------------------------------------------------------------------
module rm_lane_release_ctrl #(
  parameter int NUM_LANES = 4,
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 200
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         alloc_valid_i,
  input  logic [$clog2(NUM_LANES)-1:0] alloc_lane0_i,
  input  logic                         alloc_two_lane_i,
  input  logic [$clog2(NUM_LANES)-1:0] alloc_lane1_i,
  input  logic [NUM_LANES-1:0]         done_valid_i,
  input  logic                         flush_i,
  output logic [NUM_LANES-1:0]         lane_reset_o,
  output logic [NUM_LANES-1:0]         lane_busy_o,
  output logic                         timeout_o,
  output logic [$clog2(NUM_LANES)-1:0] timeout_lane_o,
  output logic                         err_o
);

  localparam int LW = $clog2(NUM_LANES);
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] WD_MAX  = {TIMEOUT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_RELEASE = 2'd2
  } lane_state_e;

  lane_state_e          state_q [NUM_LANES];
  lane_state_e          state_d [NUM_LANES];
  logic [1:0]           occ_q   [NUM_LANES];
  logic [1:0]           occ_d   [NUM_LANES];
  logic [TIMEOUT_W-1:0] wd_q    [NUM_LANES];
  logic [TIMEOUT_W-1:0] wd_d    [NUM_LANES];
  logic [2:0]           occ_sum [NUM_LANES];
  logic [NUM_LANES-1:0] sum_err;

  logic [NUM_LANES-1:0] inc;
  logic [NUM_LANES-1:0] dec;
  logic [NUM_LANES-1:0] fire;
  logic                 dual_same;
  logic                 lane_err;

  logic                 err_q, err_d;
  logic                 timeout_q, timeout_d;
  logic [LW-1:0]        tlane_q, tlane_d;

  // Allocation hits per lane. A two-lane allocation naming the same lane
  // twice still occupies it once, but is flagged as a protocol error.
  always_comb begin
    inc       = '0;
    dual_same = 1'b0;
    if (alloc_valid_i && !flush_i) begin
      inc[alloc_lane0_i] = 1'b1;
      if (alloc_two_lane_i) begin
        inc[alloc_lane1_i] = 1'b1;
        dual_same          = (alloc_lane1_i == alloc_lane0_i);
      end
    end
  end

  assign dec = flush_i ? '0 : done_valid_i;

  // Saturating occupancy arithmetic: occ + inc - dec clamped to 0..2.
  always_comb begin
    sum_err = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      occ_sum[i] = {1'b0, occ_q[i]} + {2'b00, inc[i]};
      if (dec[i]) begin
        if (occ_sum[i] == 3'd0) begin
          sum_err[i] = 1'b1;
        end else begin
          occ_sum[i] = occ_sum[i] - 3'd1;
        end
      end
      if (occ_sum[i] > 3'd2) begin
        occ_sum[i] = 3'd2;
        sum_err[i] = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= S_IDLE;
        occ_q[i]   <= 2'd0;
        wd_q[i]    <= '0;
      end
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      tlane_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= state_d[i];
        occ_q[i]   <= occ_d[i];
        wd_q[i]    <= wd_d[i];
      end
      err_q     <= err_d;
      timeout_q <= timeout_d;
      tlane_q   <= tlane_d;
    end
  end

  // Next-state logic
  always_comb begin
    lane_err  = dual_same;
    fire      = '0;
    timeout_d = 1'b0;
    tlane_d   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      state_d[i] = state_q[i];
      occ_d[i]   = occ_q[i];
      wd_d[i]    = wd_q[i];
      if (flush_i) begin
        // Flush wins over everything; strobes are already masked off.
        case (state_q[i])
          S_ACTIVE: begin
            state_d[i] = S_RELEASE;
            occ_d[i]   = 2'd0;
            wd_d[i]    = '0;
          end
          S_RELEASE: state_d[i] = S_IDLE;
          default:   state_d[i] = S_IDLE;
        endcase
      end else begin
        case (state_q[i])
          S_ACTIVE: begin
            lane_err = lane_err | sum_err[i];
            if (occ_sum[i] == 3'd0) begin
              state_d[i] = S_RELEASE;
              occ_d[i]   = 2'd0;
              wd_d[i]    = '0;
            end else if (wd_q[i] == WD_LAST && !dec[i]) begin
              state_d[i] = S_RELEASE;
              occ_d[i]   = 2'd0;
              wd_d[i]    = '0;
              fire[i]    = 1'b1;
            end else begin
              occ_d[i] = occ_sum[i][1:0];
              if (inc[i] || dec[i]) begin
                wd_d[i] = '0;
              end else if (wd_q[i] != WD_MAX) begin
                wd_d[i] = wd_q[i] + TIMEOUT_W'(1);
              end
            end
          end
          default: begin
            // IDLE and RELEASE hold no occupants, so any done is stray.
            // A new allocation in the RELEASE cycle re-opens the lane.
            if (dec[i]) lane_err = 1'b1;
            if (inc[i]) begin
              state_d[i] = S_ACTIVE;
              occ_d[i]   = 2'd1;
              wd_d[i]    = '0;
            end else begin
              state_d[i] = S_IDLE;
              occ_d[i]   = 2'd0;
              wd_d[i]    = '0;
            end
          end
        endcase
      end
    end
    // Lowest-index fired lane wins the report.
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (fire[i]) begin
        timeout_d = 1'b1;
        tlane_d   = LW'(i);
      end
    end
    err_d = err_q | lane_err;
  end

  // Output decode from registered state only.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_reset_o[i] = (state_q[i] == S_RELEASE);
      lane_busy_o[i]  = (state_q[i] != S_IDLE);
    end
    timeout_o      = timeout_q;
    timeout_lane_o = tlane_q;
    err_o          = err_q;
  end

endmodule

// File: tb/tb_rm_lane_release_ctrl.sv
// Testbench for rm_lane_release_ctrl: directed scenarios followed by
// randomized legal traffic, all compared against a lane-lifecycle model.
module tb_rm_lane_release_ctrl;

  localparam int NL      = 4;
  localparam int TW      = 8;
  localparam int TIMEOUT = 8;

  localparam int M_IDLE    = 0;
  localparam int M_ACTIVE  = 1;
  localparam int M_RELEASE = 2;

  // ---------------- clock / reset ----------------
  logic          clk_i;
  logic          rst_ni;
  logic          alloc_valid_i;
  logic [1:0]    alloc_lane0_i;
  logic          alloc_two_lane_i;
  logic [1:0]    alloc_lane1_i;
  logic [NL-1:0] done_valid_i;
  logic          flush_i;
  logic [NL-1:0] lane_reset_o;
  logic [NL-1:0] lane_busy_o;
  logic          timeout_o;
  logic [1:0]    timeout_lane_o;
  logic          err_o;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  rm_lane_release_ctrl #(
    .NUM_LANES(NL),
    .TIMEOUT_W(TW),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .alloc_valid_i   (alloc_valid_i),
    .alloc_lane0_i   (alloc_lane0_i),
    .alloc_two_lane_i(alloc_two_lane_i),
    .alloc_lane1_i   (alloc_lane1_i),
    .done_valid_i    (done_valid_i),
    .flush_i         (flush_i),
    .lane_reset_o    (lane_reset_o),
    .lane_busy_o     (lane_busy_o),
    .timeout_o       (timeout_o),
    .timeout_lane_o  (timeout_lane_o),
    .err_o           (err_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_state [NL];
  int m_occ   [NL];
  int m_wd    [NL];
  bit m_err;
  bit m_timeout;
  int m_tlane;

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_state[i] = M_IDLE;
      m_occ[i]   = 0;
      m_wd[i]    = 0;
    end
    m_err     = 1'b0;
    m_timeout = 1'b0;
    m_tlane   = 0;
  endtask

  task automatic model_step(input bit av, input logic [1:0] l0, input bit tl,
                            input logic [1:0] l1, input logic [NL-1:0] dn, input bit fl);
    int hit [NL];
    int d;
    int s;
    bit found;
    found = 1'b0;
    m_tlane = 0;
    for (int i = 0; i < NL; i++) hit[i] = 0;
    if (av && !fl) begin
      hit[l0] = 1;
      if (tl) begin
        hit[l1] = 1;
        if (l0 == l1) m_err = 1'b1;
      end
    end
    for (int i = 0; i < NL; i++) begin
      d = (!fl && dn[i]) ? 1 : 0;
      if (fl) begin
        if (m_state[i] == M_ACTIVE) begin
          m_state[i] = M_RELEASE;
          m_occ[i]   = 0;
        end else begin
          m_state[i] = M_IDLE;
        end
      end else if (m_state[i] == M_ACTIVE) begin
        s = m_occ[i] + hit[i] - d;
        if (s > 2) begin s = 2; m_err = 1'b1; end
        if (s < 0) begin s = 0; m_err = 1'b1; end
        if (s == 0) begin
          m_state[i] = M_RELEASE;
          m_occ[i]   = 0;
        end else if (m_wd[i] == TIMEOUT - 1 && d == 0) begin
          m_state[i] = M_RELEASE;
          m_occ[i]   = 0;
          if (!found) m_tlane = i;
          found = 1'b1;
        end else begin
          m_occ[i] = s;
          if (hit[i] != 0 || d != 0) m_wd[i] = 0;
          else if (m_wd[i] < 255) m_wd[i] = m_wd[i] + 1;
        end
      end else begin
        if (d != 0) m_err = 1'b1;
        if (hit[i] != 0) begin
          m_state[i] = M_ACTIVE;
          m_occ[i]   = 1;
          m_wd[i]    = 0;
        end else begin
          m_state[i] = M_IDLE;
          m_occ[i]   = 0;
        end
      end
    end
    m_timeout = found;
  endtask

  function automatic logic [NL-1:0] m_reset_vec();
    logic [NL-1:0] v;
    for (int i = 0; i < NL; i++) v[i] = (m_state[i] == M_RELEASE);
    return v;
  endfunction

  function automatic logic [NL-1:0] m_busy_vec();
    logic [NL-1:0] v;
    for (int i = 0; i < NL; i++) v[i] = (m_state[i] != M_IDLE);
    return v;
  endfunction

  task automatic compare_outputs(input string tag);
    check({tag, ".lane_reset"}, 32'(lane_reset_o), 32'(m_reset_vec()));
    check({tag, ".lane_busy"},  32'(lane_busy_o),  32'(m_busy_vec()));
    check({tag, ".timeout"},    32'(timeout_o),    32'(m_timeout));
    if (m_timeout) check({tag, ".timeout_lane"}, 32'(timeout_lane_o), 32'(m_tlane));
    check({tag, ".err"},        32'(err_o),        32'(m_err));
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: drive, let the rising edge sample, update the
  // model, then compare at the next falling edge.
  task automatic step(input string tag, input bit av, input logic [1:0] l0, input bit tl,
                      input logic [1:0] l1, input logic [NL-1:0] dn, input bit fl);
    alloc_valid_i    = av;
    alloc_lane0_i    = l0;
    alloc_two_lane_i = tl;
    alloc_lane1_i    = l1;
    done_valid_i     = dn;
    flush_i          = fl;
    @(posedge clk_i);
    model_step(av, l0, tl, l1, dn, fl);
    @(negedge clk_i);
    compare_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b0);
  endtask

  task automatic alloc1(input string tag, input logic [1:0] l);
    step(tag, 1'b1, l, 1'b0, 2'd0, 4'b0000, 1'b0);
  endtask

  task automatic done(input string tag, input logic [NL-1:0] dn);
    step(tag, 1'b0, 2'd0, 1'b0, 2'd0, dn, 1'b0);
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]    l0, l1;
    logic [NL-1:0] dn;
    bit            av, tl, fl;
    rst_ni           = 1'b0;
    alloc_valid_i    = 1'b0;
    alloc_lane0_i    = 2'd0;
    alloc_two_lane_i = 1'b0;
    alloc_lane1_i    = 2'd0;
    done_valid_i     = '0;
    flush_i          = 1'b0;
    model_reset();
    @(negedge clk_i);
    check("reset.lane_reset", 32'(lane_reset_o), 32'h0);
    check("reset.lane_busy",  32'(lane_busy_o),  32'h0);
    check("reset.timeout",    32'(timeout_o),    32'h0);
    check("reset.tlane",      32'(timeout_lane_o), 32'h0);
    check("reset.err",        32'(err_o),        32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // 1. single-lane release, one cycle after the done
    alloc1("t1.alloc", 2'd2);
    idle("t1.wait", 5);
    done("t1.done", 4'b0100);
    check("t1.pulse", 32'(lane_reset_o), 32'h4);
    idle("t1.after", 1);
    check("t1.pulse_gone", 32'(lane_reset_o), 32'h0);
    check("t1.busy2", 32'(lane_busy_o[2]), 32'h0);
    check("t1.err", 32'(err_o), 32'h0);

    // 2. two-lane allocation
    step("t2.alloc2", 1'b1, 2'd1, 1'b1, 2'd3, 4'b0000, 1'b0);
    alloc1("t2.alloc1", 2'd1);
    done("t2.done3", 4'b1000);
    check("t2.rel3", 32'(lane_reset_o), 32'h8);
    done("t2.done1a", 4'b0010);
    check("t2.no_rel1", 32'(lane_reset_o), 32'h0);
    done("t2.done1b", 4'b0010);
    check("t2.rel1", 32'(lane_reset_o), 32'h2);
    idle("t2.after", 1);

    // 3. simultaneous events
    alloc1("t3.alloc", 2'd0);
    step("t3.alloc_done", 1'b1, 2'd0, 1'b0, 2'd0, 4'b0001, 1'b0);
    check("t3.no_rel", 32'(lane_reset_o), 32'h0);
    check("t3.busy", 32'(lane_busy_o), 32'h1);
    done("t3.done", 4'b0001);
    check("t3.rel", 32'(lane_reset_o), 32'h1);
    alloc1("t3.realloc", 2'd0);
    check("t3.react_busy", 32'(lane_busy_o), 32'h1);
    check("t3.react_norel", 32'(lane_reset_o), 32'h0);
    done("t3.done_occ1", 4'b0001);
    check("t3.rel_occ1", 32'(lane_reset_o), 32'h1);
    idle("t3.after", 1);

    // 4. watchdog
    alloc1("t4.alloc", 2'd1);
    idle("t4.wait", TIMEOUT - 1);
    check("t4.not_yet", 32'(timeout_o), 32'h0);
    idle("t4.fire", 1);
    check("t4.timeout", 32'(timeout_o), 32'h1);
    check("t4.tlane", 32'(timeout_lane_o), 32'h1);
    check("t4.rel", 32'(lane_reset_o), 32'h2);
    idle("t4.after", 1);
    check("t4.timeout_gone", 32'(timeout_o), 32'h0);

    // 5. flush
    step("t5.alloc02", 1'b1, 2'd0, 1'b1, 2'd2, 4'b0000, 1'b0);
    alloc1("t5.alloc3", 2'd3);
    step("t5.flush", 1'b1, 2'd1, 1'b0, 2'd0, 4'b0000, 1'b1);
    check("t5.rel", 32'(lane_reset_o), 32'hd);
    check("t5.busy", 32'(lane_busy_o), 32'hd);
    idle("t5.after", 1);
    check("t5.idle", 32'(lane_busy_o), 32'h0);

    // Randomized legal traffic: no stray dones, no over-allocation.
    for (int c = 0; c < 1500; c++) begin
      av = ($urandom_range(0, 99) < 35);
      l0 = 2'($urandom_range(0, NL - 1));
      tl = ($urandom_range(0, 99) < 30);
      l1 = 2'($urandom_range(0, NL - 1));
      if (l1 == l0) l1 = l0 + 2'd1;
      if (m_state[l0] == M_ACTIVE && m_occ[l0] == 2) av = 1'b0;
      if (tl && m_state[l1] == M_ACTIVE && m_occ[l1] == 2) av = 1'b0;
      dn = '0;
      for (int i = 0; i < NL; i++)
        if (m_state[i] == M_ACTIVE && $urandom_range(0, 99) < 20) dn[i] = 1'b1;
      fl = ($urandom_range(0, 99) < 3);
      step("rand", av, l0, tl, l1, dn, fl);
    end
    idle("rand.drain", 2);

    // 6. protocol errors and reset
    apply_reset();
    done("t6.stray", 4'b0001);
    check("t6.err_set", 32'(err_o), 32'h1);
    idle("t6.sticky", 3);
    check("t6.err_sticky", 32'(err_o), 32'h1);
    apply_reset();
    alloc1("t6.a1", 2'd2);
    alloc1("t6.a2", 2'd2);
    check("t6.err_ok", 32'(err_o), 32'h0);
    alloc1("t6.a3", 2'd2);
    check("t6.err_sat", 32'(err_o), 32'h1);
    done("t6.d1", 4'b0100);
    check("t6.sat_hold", 32'(lane_reset_o), 32'h0);
    done("t6.d2", 4'b0100);
    check("t6.sat_rel", 32'(lane_reset_o), 32'h4);
    alloc1("t6.a_mid", 2'd3);
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    check("t6.rst.lane_reset", 32'(lane_reset_o), 32'h0);
    check("t6.rst.lane_busy",  32'(lane_busy_o),  32'h0);
    check("t6.rst.timeout",    32'(timeout_o),    32'h0);
    check("t6.rst.tlane",      32'(timeout_lane_o), 32'h0);
    check("t6.rst.err",        32'(err_o),        32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle("t6.post", 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
